// File: rtl/toggle_event_decoder_if.sv
// ============================================================================
// Module      : toggle_event_decoder_if
// Description : Control, event line and result bundle of toggle_event_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface toggle_event_decoder_if #(
  parameter int CNT_W = 8,
  parameter int PER_W = 8
);
  logic             en;
  logic             clr;
  logic             t_in;
  logic             ev_pulse;
  logic [CNT_W-1:0] ev_count;
  logic [PER_W-1:0] period;
  logic             period_valid;
  logic             stall;

  modport master (
    output en, clr, t_in,
    input  ev_pulse, ev_count, period, period_valid, stall
  );

  modport slave (
    input  en, clr, t_in,
    output ev_pulse, ev_count, period, period_valid, stall
  );
endinterface

`default_nettype wire

// File: rtl/toggle_event_decoder.sv
// ============================================================================
// Module      : toggle_event_decoder
// Description : Decodes a toggle-encoded event line into pulses, an event
//               count, the inter-event period and a stall flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_event_decoder #(
  parameter int CNT_W   = 8,
  parameter int PER_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  toggle_event_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam logic [PER_W-1:0] PER_MAX     = '1;
  localparam logic [PER_W:0]   TIMEOUT_EXT = (PER_W+1)'(TIMEOUT);

  state_t           state_q, state_d;
  logic             t_s1_q, t_s1_d;
  logic             t_s2_q, t_s2_d;
  logic             t_prev_q, t_prev_d;
  logic [PER_W-1:0] gap_q, gap_d;
  logic             ev_pulse_q, ev_pulse_d;
  logic [CNT_W-1:0] ev_count_q, ev_count_d;
  logic [PER_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             stall_q, stall_d;

  logic             det;
  logic [PER_W:0]   gap_inc;
  logic [PER_W-1:0] gap_sat;

  always_comb begin
    // The synchroniser runs unconditionally so clr never leaves a stale edge behind.
    t_s1_d   = bus.t_in;
    t_s2_d   = t_s1_q;
    t_prev_d = t_s2_q;

    det     = bus.en & ~bus.clr & (t_s2_q ^ t_prev_q);
    gap_inc = {1'b0, gap_q} + {{PER_W{1'b0}}, 1'b1};
    gap_sat = gap_inc[PER_W] ? PER_MAX : gap_inc[PER_W-1:0];

    state_d        = state_q;
    gap_d          = gap_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    ev_pulse_d     = det;
    ev_count_d     = det ? ev_count_q + {{(CNT_W-1){1'b0}}, 1'b1} : ev_count_q;

    if (bus.clr) begin
      state_d        = ST_IDLE;
      gap_d          = '0;
      period_d       = '0;
      period_valid_d = 1'b0;
      ev_count_d     = '0;
    end else if (bus.en) begin
      case (state_q)
        ST_IDLE: begin
          gap_d = '0;
          if (det) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (det) begin
            period_d       = gap_sat;
            period_valid_d = 1'b1;
            gap_d          = '0;
          end else begin
            gap_d = gap_sat;
            if (gap_inc == TIMEOUT_EXT) begin
              state_d = ST_STALL;
            end
          end
        end
        ST_STALL: begin
          if (det) begin
            period_d       = gap_sat;
            period_valid_d = 1'b1;
            gap_d          = '0;
            state_d        = ST_RUN;
          end else begin
            gap_d = gap_sat;
          end
        end
        default: begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end
      endcase
    end

    stall_d = (state_d == ST_STALL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      t_s1_q         <= 1'b0;
      t_s2_q         <= 1'b0;
      t_prev_q       <= 1'b0;
      gap_q          <= '0;
      ev_pulse_q     <= 1'b0;
      ev_count_q     <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      stall_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      t_s1_q         <= t_s1_d;
      t_s2_q         <= t_s2_d;
      t_prev_q       <= t_prev_d;
      gap_q          <= gap_d;
      ev_pulse_q     <= ev_pulse_d;
      ev_count_q     <= ev_count_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      stall_q        <= stall_d;
    end
  end

  assign bus.ev_pulse     = ev_pulse_q;
  assign bus.ev_count     = ev_count_q;
  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.stall        = stall_q;

endmodule

`default_nettype wire

// File: doc/toggle_event_decoder.md
Name: toggle_event_decoder

Overview:
- Receive end of a toggle-encoded event line, e.g. the q output of a T flip-flop that flips once per event.
- Synchronises the line, detects every level change, emits one single-cycle pulse per change and counts events.
- Measures the clock cycles between consecutive events and flags a stall when the line stops toggling.
- Sits downstream of T-flip-flop event sources and feeds counters and display logic.

Parameters:
- CNT_W, 8: width of the event counter.
- PER_W, 8: width of the period measurement and the gap counter.
- TIMEOUT, 16: number of enabled cycles without a toggle before stall. Legal range is 1 to 2^PER_W-1.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  asynchronous, active-low reset. reset=0 clears all state immediately.
- en  input  1  decode enable. Toggles seen while en=0 are dropped, not queued.
- clr  input  1  synchronous clear of counters, period and state.
- t_in  input  1  toggle-encoded event line; may be asynchronous to clk.
- ev_pulse  output  1  one-cycle pulse per detected toggle.
- ev_count  output  CNT_W  number of detected toggles, modulo 2^CNT_W.
- period  output  PER_W  cycles between the last two detected toggles, saturating.
- period_valid  output  1  period holds a real measurement.
- stall  output  1  no toggle for TIMEOUT enabled cycles after activity.

Behaviour:
- Reset values (reset=0): t_s1, t_s2, t_prev, gap, ev_pulse, ev_count, period, period_valid and stall are all 0; state=IDLE. Reset takes effect mid-operation without waiting for a clock edge.
- Synchroniser: every edge, t_s1<=t_in, t_s2<=t_s1, t_prev<=t_s2, regardless of en and clr.
- Detect is combinational: det = en & ~clr & (t_s2 != t_prev).
- Latency: t_in changes before edge N. t_s1 updates at edge N and t_s2 at N+1. ev_pulse<=1 at edge N+2 and drops at N+3, unless another toggle is pending. All outputs are registered.
- Back-to-back toggles: t_in flipping every cycle gives ev_pulse high continuously and ev_count +1 every cycle.
- ev_count increments on the same edge ev_pulse is set. It wraps from 2^CNT_W-1 to 0.
- State machine, IDLE / RUN / STALL:
  - IDLE: gap held at 0. On det go to RUN, gap<=0, period_valid stays 0 because the first event has no reference.
  - RUN, no det: gap<=gap+1, saturating at 2^PER_W-1. When gap+1==TIMEOUT go to STALL on that edge.
  - RUN, det: period<=min(gap+1, 2^PER_W-1), period_valid<=1, gap<=0, stay in RUN.
  - STALL, no det: gap keeps incrementing, saturating.
  - STALL, det: period<=min(gap+1, max), period_valid<=1, gap<=0, go to RUN.
- stall = (state==STALL), registered with the state.
- en=0: state, gap, period, period_valid and ev_count hold; ev_pulse<=0.
- clr=1 at an edge: ev_count=0, period=0, period_valid=0, gap=0, state=IDLE, ev_pulse=0. clr wins over a simultaneous toggle; that event is lost. The synchroniser still advances, so no phantom event follows clr.
- No toggle is ever double-counted. A held t_in level produces no further pulses.

Test Plan:
- Reset then toggle: reset low 2 cycles, release, flip t_in once before edge N -> ev_pulse high exactly one cycle after edge N+2; ev_count=1; period_valid=0; state RUN.
- Steady 4-cycle toggling: t_in flips every 4 clk for 6 events -> ev_count=6, period=4 from the second event on, period_valid=1, stall=0.
- Every-cycle toggling (T flip-flop with en=1 clocked by clk): 10 edges -> ev_pulse high 10 consecutive cycles, ev_count=10, period=1.
- Stall and recover, TIMEOUT=16: toggle, then hold t_in -> stall=1 on the 16th enabled cycle after detection. Toggle again after 20 quiet cycles -> stall=0 and period=21 on the detecting edge.
- Enable, clear and wrap: hold en=0 and toggle 3 times -> ev_count unchanged, no pulse. Assert clr on the same cycle as a pending det -> ev_count=0, period_valid=0, IDLE. With CNT_W=8, 256 toggles wrap ev_count to 0.
- Asynchronous reset mid-run: pull reset low between edges during RUN with ev_count=5 -> all outputs 0 immediately, before the next edge; decoding resumes correctly after release.
